uimac_tx_pause_sched: RTL
=========================

UIMAC_TX_PAUSE_SCHED -- requirements
Module: uimac_tx_pause_sched

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, meaning idle cycles (bytes) enforced after each frame.
REQ-002 SHALL have parameter PT_W, default 22, meaning the pause-time width in byte-clock units.
REQ-003 SHALL have port I_clk input 1, the single clock; all logic is in this domain.
REQ-004 SHALL have port I_reset_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port I_pause_en input 1, a one-cycle strobe meaning a PAUSE frame was received.
REQ-006 SHALL have port I_pause_time input PT_W, the pause duration in cycles, valid with I_pause_en.
REQ-007 SHALL have port I_req0 input 1, the IP-path TX request, level, held until granted.
REQ-008 SHALL have port I_req1 input 1, the ARP-path TX request, level, held until granted.
REQ-009 SHALL have port I_last input 1, asserted by the granted source on the final byte cycle of its frame.
REQ-010 SHALL have port O_gnt0 output 1, the grant to the IP path.
REQ-011 SHALL have port O_gnt1 output 1, the grant to the ARP path.
REQ-012 SHALL have port O_paused output 1, high while the pause counter is nonzero.
REQ-013 SHALL have port O_busy output 1, high in states GRANT and IFG.

Function
REQ-014 SHALL implement the FSM IDLE -> GRANT -> IFG -> IDLE; all outputs are registered.
REQ-015 IDLE: when (I_req0|I_req1) and pause_cnt==0 and !I_pause_en, SHALL go to GRANT with exactly one gnt high on the next cycle (1-cycle latency).
REQ-016 Arbitration SHALL be round-robin: if both request, grant the one not granted last; the pointer after reset favours req0.
REQ-017 GRANT: gnt SHALL hold regardless of req; on I_last high, gnt drops on the next cycle and the FSM enters IFG.
REQ-018 IFG: SHALL count IFG_CYCLES cycles, then return to IDLE; no grant is issued inside IFG.
REQ-019 The pause counter SHALL load I_pause_time on I_pause_en in any state and decrement by 1 per cycle while nonzero, saturating at 0.
REQ-020 A new I_pause_en during an active pause SHALL reload the counter (override, not add); a value of 0 SHALL end the pause immediately.
REQ-021 A pause SHALL NOT abort a frame in GRANT; it only blocks the next grant out of IDLE.
REQ-022 If I_pause_en and a grant decision coincide in IDLE, the pause SHALL win: no grant that cycle.
REQ-023 O_paused SHALL equal (pause_cnt != 0) registered; it is high the cycle after a nonzero load.
REQ-024 I_last while in IDLE or IFG SHALL be ignored.
REQ-025 O_gnt0 and O_gnt1 SHALL never be high simultaneously.

Reset
REQ-026 On I_reset_n low, asynchronously: state=IDLE, pause_cnt=0, ifg_cnt=0, rr pointer=req0-first, O_gnt0=O_gnt1=O_paused=O_busy=0.
REQ-027 Reset mid-frame SHALL drop the grant immediately; after release the FSM starts in IDLE with no pause pending.

Structure
REQ-028 The shared package SHALL hold the state encodings (IDLE/GRANT/IFG), IFG default 12, and the pause-time width 22.
REQ-029 The pause counter SHALL be a sub-module uimac_pause_timer (load, dec, zero flag); the arbiter/FSM is in the top.

Verification
REQ-030 I_req0 only, I_last on the 60th gnt cycle -> gnt0 for 60 cycles, O_busy stays high for 12 further IFG cycles, then IDLE.
REQ-031 I_req0 and I_req1 held continuously for 4 frames -> grants alternate 0,1,0,1, each separated by 12 idle cycles.
REQ-032 I_pause_en with time 100 while idle with req1 pending -> O_paused for 100 cycles, gnt1 on the cycle after the counter hits 0.
REQ-033 I_pause_en with time 500 mid-frame -> the frame completes normally, IFG runs, then no grant until the pause expires; a reload with 0 at count 300 -> grant resumes immediately after.
REQ-034 I_pause_en coincident with I_req0 in IDLE -> no gnt0 that cycle; the pause is honoured.
REQ-035 Reset asserted during GRANT -> gnt drops asynchronously, all outputs 0, and a request after release is granted in 1 cycle.

Source files
------------

// File: rtl/uimac_tx_pause_sched_pkg.sv
// Shared definitions for the TX pause-aware scheduler: FSM state encodings,
// default inter-frame gap, default pause-time width and the registered grant bundle.
package uimac_tx_pause_sched_pkg;

  localparam int unsigned IFG_CYCLES_DEF = 12;
  localparam int unsigned PT_W_DEF       = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_IFG   = 2'd2
  } sched_state_e;

  // Registered scheduler outputs, updated together from the next-state logic.
  typedef struct packed {
    logic gnt0;
    logic gnt1;
    logic busy;
  } grant_t;

endpackage

// File: rtl/uimac_tx_pause_sched_if.sv
// Bundle of the TX source / scheduler handshake and pause signals.
// master: request side (IP/ARP sources and the PAUSE receiver).
// slave : scheduler side (grants, pause and busy status).
interface uimac_tx_pause_sched_if
  import uimac_tx_pause_sched_pkg::*;
#(
  parameter int unsigned PT_W = PT_W_DEF
) ();

  logic            req0;
  logic            req1;
  logic            last;
  logic            pause_en;
  logic [PT_W-1:0] pause_time;
  logic            gnt0;
  logic            gnt1;
  logic            paused;
  logic            busy;

  modport master (
    output req0, req1, last, pause_en, pause_time,
    input  gnt0, gnt1, paused, busy
  );

  modport slave (
    input  req0, req1, last, pause_en, pause_time,
    output gnt0, gnt1, paused, busy
  );

endinterface

// File: rtl/uimac_pause_timer.sv
// PAUSE quanta countdown timer.
// I_clk, I_reset_n : clock, async active-low reset
// I_load, I_load_val: reload counter (override, never accumulate)
// I_dec             : decrement by one per cycle while nonzero
// O_active          : registered (count != 0)
// O_zero_c          : combinational (count == 0) for same-cycle decisions
module uimac_pause_timer
  import uimac_tx_pause_sched_pkg::*;
#(
  parameter int unsigned PT_W = PT_W_DEF
) (
  input  logic            I_clk,
  input  logic            I_reset_n,
  input  logic            I_load,
  input  logic            I_dec,
  input  logic [PT_W-1:0] I_load_val,
  output logic            O_active,
  output logic            O_zero_c
);

  logic [PT_W-1:0] cnt_q;
  logic [PT_W-1:0] cnt_nxt;

  // Load has priority over decrement; decrement saturates at zero.
  always_comb begin
    cnt_nxt = cnt_q;
    if (I_load) begin
      cnt_nxt = I_load_val;
    end else if (I_dec && (cnt_q != '0)) begin
      cnt_nxt = cnt_q - PT_W'(1);
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      cnt_q    <= '0;
      O_active <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      O_active <= (cnt_nxt != '0);
    end
  end

  assign O_zero_c = (cnt_q == '0);

endmodule

// File: rtl/uimac_tx_pause_sched.sv
// TX scheduler: round-robin grant between IP (req0) and ARP (req1) paths,
// inter-frame gap enforcement and PAUSE-frame back-off.
// I_clk, I_reset_n          : clock, async active-low reset
// I_pause_en, I_pause_time  : PAUSE received strobe and its duration
// I_req0, I_req1            : level requests, held until granted
// I_last                    : final byte of the granted frame
// O_gnt0, O_gnt1            : registered grants (mutually exclusive)
// O_paused                  : registered pause-active flag
// O_busy                    : registered, high in GRANT and IFG
module uimac_tx_pause_sched
  import uimac_tx_pause_sched_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = IFG_CYCLES_DEF,
  parameter int unsigned PT_W       = PT_W_DEF
) (
  input  logic            I_clk,
  input  logic            I_reset_n,
  input  logic            I_pause_en,
  input  logic [PT_W-1:0] I_pause_time,
  input  logic            I_req0,
  input  logic            I_req1,
  input  logic            I_last,
  output logic            O_gnt0,
  output logic            O_gnt1,
  output logic            O_paused,
  output logic            O_busy
);

  localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

  sched_state_e     state_q, state_nxt;
  logic [IFG_W-1:0] ifg_q, ifg_nxt;
  logic             pref1_q, pref1_nxt;
  grant_t           out_q, out_nxt;
  logic             pick1_c;
  logic             pause_zero_c;

  uimac_pause_timer #(
    .PT_W (PT_W)
  ) u_pause_timer (
    .I_clk      (I_clk),
    .I_reset_n  (I_reset_n),
    .I_load     (I_pause_en),
    .I_dec      (1'b1),
    .I_load_val (I_pause_time),
    .O_active   (O_paused),
    .O_zero_c   (pause_zero_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state_q;
    ifg_nxt   = ifg_q;
    pref1_nxt = pref1_q;
    out_nxt   = out_q;
    pick1_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_nxt = '0;
        // A pause strobe in the same cycle wins over the grant decision.
        if ((I_req0 || I_req1) && pause_zero_c && !I_pause_en) begin
          pick1_c      = (I_req0 && I_req1) ? pref1_q : I_req1;
          state_nxt    = ST_GRANT;
          out_nxt.gnt0 = !pick1_c;
          out_nxt.gnt1 = pick1_c;
          out_nxt.busy = 1'b1;
          pref1_nxt    = !pick1_c;
        end
      end
      ST_GRANT: begin
        // Grant is held regardless of request or pause until end of frame.
        if (I_last) begin
          state_nxt    = ST_IFG;
          ifg_nxt      = '0;
          out_nxt.gnt0 = 1'b0;
          out_nxt.gnt1 = 1'b0;
          out_nxt.busy = 1'b1;
        end
      end
      ST_IFG: begin
        if (ifg_q == IFG_LAST) begin
          state_nxt = ST_IDLE;
          out_nxt   = '0;
        end else begin
          ifg_nxt = ifg_q + IFG_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        out_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= ST_IDLE;
      ifg_q   <= '0;
      pref1_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_nxt;
      ifg_q   <= ifg_nxt;
      pref1_q <= pref1_nxt;
      out_q   <= out_nxt;
    end
  end

  assign O_gnt0 = out_q.gnt0;
  assign O_gnt1 = out_q.gnt1;
  assign O_busy = out_q.busy;

endmodule
